// File: rtl/tmr_binary_counter.sv
// Free-running binary up-counter with enable and clears.
// Optional triple-redundant state, scrubbed through the voted value.
module tmr_binary_counter #(
  parameter int Width = 4,
  parameter bit TMR   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SRST,
  input  logic             CE,
  output logic [Width-1:0] Q,
  output logic             TC,
  output logic             CEO
);

  logic [Width-1:0] v;
  logic [Width-1:0] cnt_d;

  // Next value always comes from the voted count, never a single copy.
  always_comb begin
    cnt_d = v;
    if (SRST)
      cnt_d = '0;
    else if (CE)
      cnt_d = v + Width'(1);
  end

  generate
    if (TMR) begin : g_tmr
      (* keep = "true", preserve = "true", dont_touch = "true" *)
      logic [Width-1:0] a_q = '0;
      (* keep = "true", preserve = "true", dont_touch = "true" *)
      logic [Width-1:0] b_q = '0;
      (* keep = "true", preserve = "true", dont_touch = "true" *)
      logic [Width-1:0] c_q = '0;

      always_ff @(posedge CLK) begin
        if (RST) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= '0;
        end else begin
          a_q <= cnt_d;
          b_q <= cnt_d;
          c_q <= cnt_d;
        end
      end

      assign v = (a_q & b_q) | (b_q & c_q) | (a_q & c_q);
    end else begin : g_single
      logic [Width-1:0] q_q = '0;

      always_ff @(posedge CLK) begin
        if (RST)
          q_q <= '0;
        else
          q_q <= cnt_d;
      end

      assign v = q_q;
    end
  endgenerate

  assign Q   = v;
  assign TC  = &v;
  assign CEO = TC & CE;

endmodule

// File: tb/tb_tmr_binary_counter.sv
// Bench for tmr_binary_counter: 4-bit plain/TMR, 2-bit and 1-bit builds.
// Vector table plus scoreboard queue, then copy-upset scrubbing checks.
module tb_tmr_binary_counter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SRST = 1'b0;
  logic CE = 1'b0;

  logic [3:0] q4, q4t;
  logic [1:0] q2, q2t;
  logic       q1;
  logic tc4, tc4t, tc2, tc2t, tc1;
  logic ceo4, ceo4t, ceo2, ceo2t, ceo1;

  always #5 CLK = ~CLK;

  tmr_binary_counter #(.Width(4), .TMR(1'b0)) dut4 (
    .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE),
    .Q(q4), .TC(tc4), .CEO(ceo4)
  );
  tmr_binary_counter #(.Width(4), .TMR(1'b1)) dut4t (
    .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE),
    .Q(q4t), .TC(tc4t), .CEO(ceo4t)
  );
  tmr_binary_counter #(.Width(2), .TMR(1'b0)) dut2 (
    .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE),
    .Q(q2), .TC(tc2), .CEO(ceo2)
  );
  tmr_binary_counter #(.Width(2), .TMR(1'b1)) dut2t (
    .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE),
    .Q(q2t), .TC(tc2t), .CEO(ceo2t)
  );
  tmr_binary_counter #(.Width(1), .TMR(1'b0)) dut1 (
    .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE),
    .Q(q1), .TC(tc1), .CEO(ceo1)
  );

  typedef struct {
    logic rst;
    logic srst;
    logic ce;
    int   q4;
  } vec_t;

  typedef struct {
    int q4;
    int q2;
    int q1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cur4 = 0;
  int m2 = 0;
  int m1 = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s,
                     input logic c, input int q);
    vec_t v;
    v.rst = r;
    v.srst = s;
    v.ce = c;
    v.q4 = q;
    tbl.push_back(v);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input vec_t v);
    exp_t e;
    int t4, t2, t1;
    RST = v.rst;
    SRST = v.srst;
    CE = v.ce;
    #1;
    t4 = (cur4 == 15) ? 1 : 0;
    t2 = (m2 == 3) ? 1 : 0;
    t1 = (m1 == 1) ? 1 : 0;
    chk("tc4", int'(tc4), t4);
    chk("ceo4", int'(ceo4), t4 & int'(v.ce));
    chk("tc4t", int'(tc4t), t4);
    chk("ceo4t", int'(ceo4t), t4 & int'(v.ce));
    chk("tc2", int'(tc2), t2);
    chk("ceo2t", int'(ceo2t), t2 & int'(v.ce));
    chk("tc1", int'(tc1), t1);
    chk("ceo1", int'(ceo1), t1 & int'(v.ce));
    if (v.rst || v.srst) begin
      m2 = 0;
      m1 = 0;
    end else if (v.ce) begin
      m2 = (m2 + 1) % 4;
      m1 = (m1 + 1) % 2;
    end
    cur4 = v.q4;
    e.q4 = v.q4;
    e.q2 = m2;
    e.q1 = m1;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("q4", int'(q4), e.q4);
    chk("q4t", int'(q4t), e.q4);
    chk("q2", int'(q2), e.q2);
    chk("q2t", int'(q2t), e.q2);
    chk("q1", int'(q1), e.q1);
    @(negedge CLK);
  endtask

  initial begin
    vec_t v;
    // reset with CE high, then free run 17 edges
    add(1, 0, 1, 0);
    add(1, 0, 1, 0);
    for (int i = 1; i <= 15; i++) add(0, 0, 1, i);
    add(0, 0, 1, 0);
    add(0, 0, 1, 1);
    // enable gating
    add(1, 0, 1, 0);
    for (int i = 1; i <= 3; i++) add(0, 0, 1, i);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 3);
    add(0, 0, 1, 4);
    add(0, 0, 1, 5);
    // hold at terminal count with CE low
    for (int i = 6; i <= 15; i++) add(0, 0, 1, i);
    add(0, 0, 0, 15);
    add(0, 0, 0, 15);
    add(0, 0, 1, 0);
    // clear priority
    for (int i = 1; i <= 9; i++) add(0, 0, 1, i);
    add(0, 1, 1, 0);
    for (int i = 1; i <= 3; i++) add(0, 0, 1, i);
    add(1, 1, 1, 0);
    add(0, 0, 1, 1);
    add(0, 0, 1, 2);
    add(0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) add(0, 0, 1, i);

    @(negedge CLK);
    foreach (tbl[i]) step(tbl[i]);
    chk("sb_empty", sb.size(), 0);

    // upset copy B with CE low: output stays, copy is scrubbed
    CE = 1'b0;
    dut4t.g_tmr.b_q = 4'(~cur4);
    #1;
    chk("upset_q", int'(q4t), cur4);
    chk("upset_tc", int'(tc4t), (cur4 == 15) ? 1 : 0);
    @(negedge CLK);
    v.rst = 0;
    v.srst = 0;
    v.ce = 0;
    v.q4 = cur4;
    step(v);
    chk("scrub_hold", int'(dut4t.g_tmr.b_q), cur4);

    // upset copy B while counting
    dut4t.g_tmr.b_q = 4'hF;
    #1;
    chk("upset2_q", int'(q4t), cur4);
    @(negedge CLK);
    v.ce = 1;
    v.q4 = (cur4 + 1) % 16;
    step(v);
    chk("scrub_cnt", int'(dut4t.g_tmr.b_q), (cur4) % 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_binary_counter.md
Name: tmr_binary_counter

Overview:
- Parameterised free-running binary up-counter with clock enable, synchronous reset and an extra synchronous clear.
- Optional triple-modular-redundant (TMR) register storage with majority voting.
- Used as a state/phase sequencer (e.g. 4-bit, 16-phase block timing) and as an event counter that is cleared at block boundaries.
- One instance covers both roles:
  - Sequencer: tie SRST=0, CE=1.
  - Event counter: drive SRST from the block-end strobe, CE from the event.

Parameters:
- Width, 4, counter width in bits (legal 1..32).
- TMR, 0, 0 = single register set; 1 = three register copies, voted output.

Ports:
- CLK  input  1  rising-edge clock for all state.
- RST  input  1  synchronous active-high reset; Q to 0.
- SRST  input  1  synchronous active-high clear; Q to 0. Functionally identical to RST, kept separate for block-boundary clears.
- CE  input  1  count enable; Q increments when high.
- Q  output  Width  current count (voted value when TMR=1).
- TC  output  1  terminal count: high when Q == all ones.
- CEO  output  1  carry out: TC & CE, for cascading.

Behaviour:
- All registers update only on rising CLK; no asynchronous paths.
- Power-up (initial) value of all register copies: 0.
- Priority at each rising edge:
  - RST=1: Q <= 0.
  - else SRST=1: Q <= 0.
  - else CE=1: Q <= Q + 1.
  - else Q holds.
- Clear dominates CE: RST or SRST asserted together with CE gives Q=0, not 1.
- Arithmetic:
  - Unsigned, modulo 2^Width.
  - From all ones with CE=1, Q wraps to 0. No saturation and no sticky flag.
- Latency: Q reflects an enable or clear one clock after the sampling edge.
- Output logic:
  - TC and CEO are combinational from Q and CE; no registered delay.
  - TC = 1 iff Q == 2^Width-1.
  - CEO = TC & CE.
  - On reset, Q=0, so TC=0 and CEO=0 (except Width=1 corner, where TC=(Q==1) still holds and is 0 after reset).
- TMR=0: single Width-bit register.
- TMR=1:
  - Three Width-bit registers A, B, C.
  - Bitwise majority V = (A&B)|(B&C)|(A&C).
  - Each copy loads next = clear ? 0 : (CE ? V+1 : V), computed from V, not from its own value. A single upset copy is therefore scrubbed on the next clock edge even when CE=0.
  - Q = V.
  - Cycle behaviour at Q is identical to TMR=0.
  - Copies must not be merged by synthesis; apply keep/preserve attributes to the three registers.
- Reset mid-count: the next edge forces 0. Counting resumes from 0 on the first edge after RST and SRST are both low with CE high.
- X/unknown on CE or SRST is not handled specially.

Test Plan:
- Reset: hold RST=1 for 2 clocks with CE=1 -> Q=0, TC=0, CEO=0. Release RST -> Q=1 after the first edge, 2 after the second.
- Free run (Width=4, CE=1, SRST=0): 17 edges after reset -> Q sequence 1..15, 0, 1. TC=1 only while Q=15. CEO=1 in that same cycle.
- Enable gating: CE=1 for 3 edges, CE=0 for 5 edges, CE=1 for 2 edges -> Q=3 held through the CE=0 window, then 5. CEO=0 whenever CE=0, even at Q=15.
- Clear priority: at Q=9 assert SRST and CE together for one edge -> Q=0. Assert RST and SRST together -> Q=0. SRST with CE=0 -> Q=0.
- Wrap with Width=2: CE=1 for 4 edges -> Q 1, 2, 3, 0. TC=1 at Q=3.
- TMR equivalence: run the above sequences with TMR=1 against TMR=0 -> Q, TC and CEO match every cycle. Force copy B to a wrong value via hierarchical deposit -> Q unaffected, and B equals A within one clock.
